// File: rtl/active_vertex_issue_if.sv
// Bitmap read bus and active-vertex issue stream of the vertex issue stage.
// master = issue stage, slave = bitmap memory / offset-read stage.
interface active_vertex_issue_if #(
    parameter int V_ID_WIDTH = 20,
    parameter int BMP_AWIDTH = 10
);
    logic                  bitmap_rd_en;
    logic [BMP_AWIDTH-1:0] bitmap_rd_addr;
    logic [31:0]           bitmap_rd_data;
    logic [V_ID_WIDTH-1:0] active_v_id;
    logic                  active_v_valid;
    logic                  next_stage_full;

    modport master (
        output bitmap_rd_en,
        output bitmap_rd_addr,
        input  bitmap_rd_data,
        output active_v_id,
        output active_v_valid,
        input  next_stage_full
    );

    modport slave (
        input  bitmap_rd_en,
        input  bitmap_rd_addr,
        output bitmap_rd_data,
        input  active_v_id,
        input  active_v_valid,
        output next_stage_full
    );
endinterface

// File: rtl/active_vertex_issue.sv
// Scans the active-vertex bitmap of one iteration and issues one vertex id per cycle.
// Optional issued-id counter output enabled by macro ACTIVE_ISSUE_COUNT_EN.
module active_vertex_issue #(
    parameter int V_ID_WIDTH      = 20,
    parameter int ITERATION_WIDTH = 8,
    parameter int CORE_NUM_WIDTH  = 5,
    parameter int CORE_ID         = 0,
    parameter int BMP_AWIDTH      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ITERATION_WIDTH-1:0] start_iteration_id,
    input  logic [BMP_AWIDTH:0]        word_count,
    active_vertex_issue_if.master      bus,
    output logic                       iteration_end,
    output logic                       iteration_end_valid,
    output logic [ITERATION_WIDTH-1:0] iteration_id,
    output logic                       busy
`ifdef ACTIVE_ISSUE_COUNT_EN
    ,
    output logic [V_ID_WIDTH-1:0]      issued_count
`endif
);

    localparam int IW    = BMP_AWIDTH + 1;
    localparam int RAW_W = BMP_AWIDTH + 5 + CORE_NUM_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SCAN,
        END
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]         idx, idx_n, idx_inc;
    logic [IW-1:0]         wcnt, wcnt_n;
    logic [31:0]           word, word_n;
    logic [4:0]            bit_sel;
    logic                  issue;
    logic                  accept;
    logic [RAW_W-1:0]      raw_id;
    logic [V_ID_WIDTH-1:0] v_id_n;

    // lowest set bit of the working word
    always_comb begin
        bit_sel = '0;
        for (int i = 31; i >= 0; i--) begin
            if (word[i]) bit_sel = 5'(i);
        end
    end

    assign idx_inc = idx + IW'(1);
    assign raw_id  = {idx[BMP_AWIDTH-1:0], bit_sel,
                      CORE_NUM_WIDTH'(CORE_ID)};
    assign v_id_n  = V_ID_WIDTH'(raw_id);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        wcnt_n  = wcnt;
        word_n  = word;
        issue   = 1'b0;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    wcnt_n  = word_count;
                    idx_n   = '0;
                    state_n = (word_count == '0) ? END : FETCH;
                end
            end
            FETCH: state_n = WAIT;
            WAIT: begin
                word_n  = bus.bitmap_rd_data;
                state_n = SCAN;
            end
            SCAN: begin
                if (word == '0) begin
                    idx_n   = idx_inc;
                    state_n = (idx_inc < wcnt) ? FETCH : END;
                end else if (!bus.next_stage_full) begin
                    issue  = 1'b1;
                    word_n = word & (word - 32'd1);
                end
            end
            END:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            wcnt  <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            wcnt  <= wcnt_n;
            word  <= word_n;
        end
    end

    // read strobe leads the WAIT capture by exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.bitmap_rd_en    <= 1'b0;
            bus.bitmap_rd_addr  <= '0;
            bus.active_v_valid  <= 1'b0;
            bus.active_v_id     <= '0;
            iteration_end       <= 1'b0;
            iteration_end_valid <= 1'b0;
            iteration_id        <= '0;
            busy                <= 1'b0;
        end else begin
            bus.bitmap_rd_en    <= (state_n == FETCH);
            if (state_n == FETCH)
                bus.bitmap_rd_addr <= idx_n[BMP_AWIDTH-1:0];
            bus.active_v_valid  <= issue;
            if (issue)
                bus.active_v_id <= v_id_n;
            iteration_end       <= (state == END);
            iteration_end_valid <= (state == END);
            if (accept)
                iteration_id <= start_iteration_id;
            busy                <= (state_n != IDLE);
        end
    end

`ifdef ACTIVE_ISSUE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            issued_count <= '0;
        else if (accept)
            issued_count <= '0;
        else if (issue)
            issued_count <= issued_count + V_ID_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_active_vertex_issue.sv
// Scoreboard bench for active_vertex_issue: bitmap memory model, random backpressure.
// Expected ids come from a bit-by-bit walk of the bitmap contents.
module tb_active_vertex_issue;

    localparam int VW  = 20;
    localparam int ITW = 8;
    localparam int CNW = 5;
    localparam int CID = 3;
    localparam int AW  = 4;
    localparam int NW  = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [ITW-1:0] start_iteration_id = '0;
    logic [AW:0]    word_count = '0;
    logic           iteration_end;
    logic           iteration_end_valid;
    logic [ITW-1:0] iteration_id;
    logic           busy;
`ifdef ACTIVE_ISSUE_COUNT_EN
    logic [VW-1:0]  issued_count;
`endif

    active_vertex_issue_if #(.V_ID_WIDTH(VW), .BMP_AWIDTH(AW)) bus ();

    active_vertex_issue #(
        .V_ID_WIDTH(VW), .ITERATION_WIDTH(ITW), .CORE_NUM_WIDTH(CNW),
        .CORE_ID(CID), .BMP_AWIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_iteration_id(start_iteration_id),
        .word_count(word_count),
        .bus(bus),
        .iteration_end(iteration_end),
        .iteration_end_valid(iteration_end_valid),
        .iteration_id(iteration_id),
        .busy(busy)
`ifdef ACTIVE_ISSUE_COUNT_EN
        ,
        .issued_count(issued_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_iter, exp_reads, exp_count;
    int reads = 0, exp_addr = 0;
    int end_pending = 0, end_cnt = 0, end_ts = 0;
    logic [31:0]   mem [NW];
    logic [VW-1:0] exp_q [$];
    int            v_ts [$];
    logic rand_full = 1'b0, rnd_bit = 1'b0, full_req = 1'b0, full_seen = 1'b0;
    logic          rd_en_d = 1'b0;
    logic [AW-1:0] rd_addr_d = '0;

    assign bus.next_stage_full = rand_full ? rnd_bit : full_req;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        full_seen <= bus.next_stage_full;
    end

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 2) == 0);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bitmap memory: data valid only in the cycle after the read strobe
    always @(negedge clk) begin
        bus.bitmap_rd_data = (rd_en_d === 1'b1) ? mem[rd_addr_d] : 32'hA5A5_5A5A;
        if (bus.bitmap_rd_en === 1'b1) begin
            chk("rd_addr", bus.bitmap_rd_addr, exp_addr);
            exp_addr++;
            reads++;
        end
        rd_en_d   = bus.bitmap_rd_en;
        rd_addr_d = bus.bitmap_rd_addr;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (bus.active_v_valid === 1'b1) begin
                chk("valid_during_stall", full_seen, 0);
                chk("valid_vs_end", iteration_end_valid, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_id: got %0d expected none", bus.active_v_id);
                end else begin
                    chk("v_id", bus.active_v_id, exp_q.pop_front());
                end
                v_ts.push_back(cyc);
            end
            if (iteration_end_valid === 1'b1) begin
                if (end_pending == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_end: got 1 expected 0");
                end else begin
                    chk("ids_left", exp_q.size(), 0);
                    chk("iteration_id", iteration_id, exp_iter);
                    chk("iteration_end", iteration_end, 1);
                    chk("reads", reads, exp_reads);
`ifdef ACTIVE_ISSUE_COUNT_EN
                    chk("issued_count", issued_count, exp_count);
`endif
                end
                end_pending = 0;
                end_ts = cyc;
                end_cnt++;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_v_valid"}, bus.active_v_valid, 0);
        chk({tag, "_v_id"}, bus.active_v_id, 0);
        chk({tag, "_rd_en"}, bus.bitmap_rd_en, 0);
        chk({tag, "_rd_addr"}, bus.bitmap_rd_addr, 0);
        chk({tag, "_end"}, iteration_end, 0);
        chk({tag, "_end_valid"}, iteration_end_valid, 0);
        chk({tag, "_iter_id"}, iteration_id, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef ACTIVE_ISSUE_COUNT_EN
        chk({tag, "_count"}, issued_count, 0);
`endif
    endtask

    task automatic fill_random();
        for (int w = 0; w < NW; w++) begin
            case ($urandom_range(0, 3))
                0:       mem[w] = '0;
                1:       mem[w] = 32'h1 << $urandom_range(0, 31);
                2:       mem[w] = $urandom;
                default: mem[w] = $urandom & $urandom;
            endcase
        end
    endtask

    task automatic run(input logic [ITW-1:0] it, input int wc,
                       input bit rf, input bit extra, input int abort_n);
        int c0;
        exp_q.delete();
        v_ts.delete();
        for (int w = 0; w < wc; w++)
            for (int b = 0; b < 32; b++)
                if (mem[w][b])
                    exp_q.push_back(VW'(((w * 32 + b) << CNW) | CID));
        exp_count   = exp_q.size();
        exp_iter    = it;
        exp_reads   = wc;
        reads       = 0;
        exp_addr    = 0;
        end_pending = 1;
        c0 = end_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        start_iteration_id = it;
        word_count = wc[AW:0];
        start_cyc = cyc;
        rand_full = rf;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_iteration_id = ITW'($urandom);
        word_count = (AW + 1)'($urandom);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        if (extra && busy) begin
            start = 1'b1;
            start_iteration_id = ~it;
            word_count = (AW + 1)'(NW);
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (abort_n > 0) begin
            for (int i = 0; i < 500 && v_ts.size() < abort_n; i++)
                @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
            @(posedge clk);
            #1;
            exp_q.delete();
            end_pending = 0;
            rst = 1'b1;
            @(negedge clk);
            chk_zero("abort");
            repeat (40) @(posedge clk);
        end else begin
            for (int i = 0; i < 3000 && end_cnt == c0; i++)
                @(posedge clk);
            if (end_cnt == c0) begin
                vectors++;
                miscompares++;
                $display("FAIL end_timeout: got no end expected end");
                end_pending = 0;
                exp_q.delete();
            end
            @(negedge clk);
            chk("busy_idle", busy, 0);
        end
        rand_full = 1'b0;
        full_req  = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < NW; w++) mem[w] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // two ids from one word on consecutive cycles
        mem[0] = 32'h0000_0005;
        run(8'h5A, 1, 1'b0, 1'b0, 0);
        chk("two_ids", v_ts.size(), 2);
        if (v_ts.size() == 2)
            chk("consecutive", v_ts[1] - v_ts[0], 1);

        // empty first word, id from second word
        mem[0] = '0;
        mem[1] = 32'h0000_0001;
        run(8'h11, 2, 1'b0, 1'b0, 0);

        // stall right after the first id
        mem[0] = 32'h8000_0001;
        fork
            run(8'h42, 1, 1'b0, 1'b0, 0);
            begin
                for (int i = 0; i < 50 && bus.active_v_valid !== 1'b1; i++)
                    @(negedge clk);
                full_req = 1'b1;
                repeat (4) @(posedge clk);
                #1 full_req = 1'b0;
            end
        join
        chk("stall_ids", v_ts.size(), 2);
        if (v_ts.size() == 2)
            chk("stall_gap", v_ts[1] - v_ts[0], 5);

        // empty scan with a start while busy
        run(8'h77, 0, 1'b0, 1'b1, 0);
        chk("end_latency", end_ts - start_cyc, 2);

        // reset in the middle of a scan, then a clean rescan
        mem[0] = 32'hFFFF_FFFF;
        run(8'h33, 1, 1'b0, 1'b0, 3);
        mem[0] = 32'h0000_0080;
        run(8'h34, 1, 1'b0, 1'b0, 0);

        // full word: 32 ids
        mem[0] = 32'hFFFF_FFFF;
        run(8'h99, 1, 1'b1, 1'b0, 0);
        chk("full_word_ids", v_ts.size(), 32);

        // whole address range
        fill_random();
        run(8'hC3, NW, 1'b1, 1'b1, 0);

        for (int k = 0; k < 12; k++) begin
            fill_random();
            run(ITW'($urandom), $urandom_range(0, NW), 1'($urandom),
                1'($urandom), 0);
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
